// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Optional round-robin tie-break is enabled with MEM_BUS_ARB_RR_EN.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_OWNER_NONE = 2'd0,
        BUS_OWNER_DATA = 2'd1,
        BUS_OWNER_INST = 2'd2
    } BusOwner_t;

    localparam int MEM_BUS_ARB_WAIT_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Simple CPU memory bus: request fields from master, response from slave.
// Stall means the current request has not completed this cycle.
interface Bus_if;

    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] data_wr;
    logic [3:0]  mask;
    logic [31:0] data_rd;
    logic        stall;
    logic [5:0]  interrupt;

    modport master (
        output read, write, address, data_wr, mask,
        input  data_rd, stall, interrupt
    );

    modport slave (
        input  read, write, address, data_wr, mask,
        output data_rd, stall, interrupt
    );

endinterface

// File: rtl/mem_bus_arb_starve_cnt.sv
// Counts consecutive cycles the instruction master is kept waiting
// and raises force_inst once the limit is reached.
module mem_bus_arb_starve_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_INST_WAIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_inst,
    input  logic                          inst_win,
    input  logic                          mem_stall,
    output logic                          force_inst,
    output logic [MEM_BUS_ARB_WAIT_W-1:0] wait_cnt
);

    localparam int W = MEM_BUS_ARB_WAIT_W;
    localparam logic [W-1:0] SAT   = '1;
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] LIMIT = W'(MAX_INST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!req_inst || (inst_win && !mem_stall)) begin
            wait_cnt <= '0;
        end else if (!inst_win && wait_cnt != SAT) begin
            wait_cnt <= wait_cnt + ONE;
        end
    end

    assign force_inst = (wait_cnt >= LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction and data masters.
// Define MEM_BUS_ARB_RR_EN for round-robin tie-break instead of data priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_INST_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    Bus_if.slave       inst_bus,
    Bus_if.slave       data_bus,
    Bus_if.master      mem_bus,
    output logic [1:0] owner
);

    BusOwner_t state;
    BusOwner_t winner;
    logic      req_i;
    logic      req_d;
    logic      force_inst;
    logic      inst_win;
    logic [MEM_BUS_ARB_WAIT_W-1:0] wait_cnt;

    assign req_i    = inst_bus.read | inst_bus.write;
    assign req_d    = data_bus.read | data_bus.write;
    assign inst_win = (winner == BUS_OWNER_INST);

`ifdef MEM_BUS_ARB_RR_EN
    logic last_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_inst <= 1'b0;
        end else if (winner != BUS_OWNER_NONE && !mem_bus.stall) begin
            last_inst <= inst_win;
        end
    end
`endif

    // A locked owner keeps the bus until its stalled transfer finishes.
    always_comb begin
        winner = BUS_OWNER_NONE;
        if (rst) begin
            winner = BUS_OWNER_NONE;
        end else if (state != BUS_OWNER_NONE) begin
            winner = state;
        end else if (force_inst && req_i) begin
            winner = BUS_OWNER_INST;
`ifdef MEM_BUS_ARB_RR_EN
        end else if (req_d && req_i) begin
            winner = last_inst ? BUS_OWNER_DATA : BUS_OWNER_INST;
`endif
        end else if (req_d) begin
            winner = BUS_OWNER_DATA;
        end else if (req_i) begin
            winner = BUS_OWNER_INST;
        end
    end

    always_comb begin
        mem_bus.read    = 1'b0;
        mem_bus.write   = 1'b0;
        mem_bus.address = '0;
        mem_bus.data_wr = '0;
        mem_bus.mask    = '0;
        unique case (winner)
            BUS_OWNER_DATA: begin
                mem_bus.read    = data_bus.read;
                mem_bus.write   = data_bus.write;
                mem_bus.address = data_bus.address;
                mem_bus.data_wr = data_bus.data_wr;
                mem_bus.mask    = data_bus.mask;
            end
            BUS_OWNER_INST: begin
                mem_bus.read    = inst_bus.read;
                mem_bus.write   = inst_bus.write;
                mem_bus.address = inst_bus.address;
                mem_bus.data_wr = inst_bus.data_wr;
                mem_bus.mask    = inst_bus.mask;
            end
            default: ;
        endcase
    end

    assign inst_bus.data_rd = inst_win ? mem_bus.data_rd : '0;
    assign data_bus.data_rd =
        (winner == BUS_OWNER_DATA) ? mem_bus.data_rd : '0;

    assign inst_bus.stall = inst_win ? mem_bus.stall : (req_i & ~rst);
    assign data_bus.stall = (winner == BUS_OWNER_DATA) ?
                            mem_bus.stall : (req_d & ~rst);

    assign data_bus.interrupt = mem_bus.interrupt;
    assign inst_bus.interrupt = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUS_OWNER_NONE;
        end else if (winner != BUS_OWNER_NONE && mem_bus.stall) begin
            state <= winner;
        end else begin
            state <= BUS_OWNER_NONE;
        end
    end

    assign owner = state;

    mem_bus_arb_starve_cnt #(
        .MAX_INST_WAIT (MAX_INST_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .req_inst   (req_i),
        .inst_win   (inst_win),
        .mem_stall  (mem_bus.stall),
        .force_inst (force_inst),
        .wait_cnt   (wait_cnt)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed table, corner
// sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int MAXW = 8;
    localparam logic [31:0] IADDR = 32'hBFC0_0000;
    localparam logic [31:0] DADDR = 32'h8000_1000;
`ifdef MEM_BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] owner;

    Bus_if ib();
    Bus_if db();
    Bus_if mb();

    mem_bus_arbiter #(.MAX_INST_WAIT(MAXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst_bus (ib),
        .data_bus (db),
        .mem_bus  (mb),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Owned master must keep requesting until its transfer completes.
    always @(negedge clk) begin
        if (rst === 1'b0 && owner == 2'd1)
            assert (db.read | db.write)
            else $error("FAIL hold_data: data request dropped while owned");
        if (rst === 1'b0 && owner == 2'd2)
            assert (ib.read | ib.write)
            else $error("FAIL hold_inst: inst request dropped while owned");
    end

    task automatic drive(input bit ird, input bit iwr, input bit drd,
                         input bit dwr, input bit ms,
                         input logic [31:0] mdrd);
        ib.read = ird; ib.write = iwr; ib.address = IADDR;
        ib.data_wr = 32'h1111_1111; ib.mask = 4'hF;
        db.read = drd; db.write = dwr; db.address = DADDR;
        db.data_wr = 32'h2222_2222; db.mask = 4'h3;
        mb.stall = ms; mb.data_rd = mdrd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] sel_addr(input logic [1:0] sel);
        return (sel == 2'd1) ? DADDR : (sel == 2'd2) ? IADDR : 32'h0;
    endfunction

    typedef struct {
        bit ird; bit drd; bit dwr; bit ms;
        logic [1:0] own; bit ist; bit dst; bit mrd; bit mwr;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs[9];

    // Behavioural reference: owner 0/1/2 as plain ints.
    int m_owner, m_wait, e_win;
    bit m_last;
    bit e_ist, e_dst;
    bit ipend, dpend;

    task automatic model_eval();
        bit ri, rd;
        ri = ib.read | ib.write;
        rd = db.read | db.write;
        if (rst) e_win = 0;
        else if (m_owner != 0) e_win = m_owner;
        else if (ri && m_wait >= MAXW) e_win = 2;
        else if (ri && rd) e_win = RR ? (m_last ? 1 : 2) : 1;
        else if (rd) e_win = 1;
        else if (ri) e_win = 2;
        else e_win = 0;
        e_ist = rst ? 1'b0 : (e_win == 2) ? mb.stall : ri;
        e_dst = rst ? 1'b0 : (e_win == 1) ? mb.stall : rd;
    endtask

    task automatic model_update();
        bit ri;
        ri = ib.read | ib.write;
        if (rst) begin
            m_owner = 0; m_wait = 0; m_last = 1'b0;
        end else begin
            m_owner = (e_win != 0 && mb.stall) ? e_win : 0;
            if (!ri || (e_win == 2 && !mb.stall)) m_wait = 0;
            else if (e_win != 2 && m_wait < 255) m_wait++;
            if (e_win != 0 && !mb.stall) m_last = (e_win == 2);
        end
    endtask

    task automatic check_model(input string p);
        logic [31:0] er, ew, ea, ed, em;
        er = (e_win == 1) ? 32'(db.read) : (e_win == 2) ? 32'(ib.read) : 0;
        ew = (e_win == 1) ? 32'(db.write) : (e_win == 2) ? 32'(ib.write) : 0;
        ea = (e_win == 1) ? db.address : (e_win == 2) ? ib.address : 0;
        ed = (e_win == 1) ? db.data_wr : (e_win == 2) ? ib.data_wr : 0;
        em = (e_win == 1) ? 32'(db.mask) : (e_win == 2) ? 32'(ib.mask) : 0;
        chk({p, "owner"}, 32'(owner), 32'(m_owner));
        chk({p, "wait_cnt"}, 32'(dut.u_starve.wait_cnt), 32'(m_wait));
        chk({p, "mem_read"}, 32'(mb.read), er);
        chk({p, "mem_write"}, 32'(mb.write), ew);
        if (!rst) begin
            chk({p, "mem_addr"}, mb.address, ea);
            chk({p, "mem_wdata"}, mb.data_wr, ed);
            chk({p, "mem_mask"}, 32'(mb.mask), em);
        end
        chk({p, "inst_stall"}, 32'(ib.stall), 32'(e_ist));
        chk({p, "data_stall"}, 32'(db.stall), 32'(e_dst));
        chk({p, "inst_rdata"}, ib.data_rd, (e_win == 2) ? mb.data_rd : 0);
        chk({p, "data_rdata"}, db.data_rd, (e_win == 1) ? mb.data_rd : 0);
        chk({p, "data_irq"}, 32'(db.interrupt), 32'(mb.interrupt));
        chk({p, "inst_irq"}, 32'(ib.interrupt), 32'h0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        mb.interrupt = 6'h0;
        drive(0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_wait", 32'(dut.u_starve.wait_cnt), 32'h0);
        chk("rst_mem_read", 32'(mb.read), 32'h0);
        next_cycle();
        rst = 1'b0;

`ifndef MEM_BUS_ARB_RR_EN
        vecs[0] = '{1, 0, 0, 0, 2'd0, 0, 0, 1, 0, 2'd2};
        vecs[1] = '{0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0};
        vecs[2] = '{1, 0, 1, 1, 2'd0, 1, 1, 0, 1, 2'd1};
        vecs[3] = '{1, 0, 1, 1, 2'd1, 1, 1, 0, 1, 2'd1};
        vecs[4] = '{1, 0, 1, 1, 2'd1, 1, 1, 0, 1, 2'd1};
        vecs[5] = '{1, 0, 1, 0, 2'd1, 1, 0, 0, 1, 2'd1};
        vecs[6] = '{1, 0, 0, 0, 2'd0, 0, 0, 1, 0, 2'd2};
        vecs[7] = '{0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0};
        vecs[8] = '{0, 1, 0, 0, 2'd0, 0, 0, 1, 0, 2'd1};
        for (int i = 0; i < 9; i++) begin
            logic [31:0] d;
            d = 32'hC0DE_0000 + 32'(i);
            drive(vecs[i].ird, 0, vecs[i].drd, vecs[i].dwr, vecs[i].ms, d);
            @(negedge clk);
            chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].own));
            chk($sformatf("v%0d_istall", i), 32'(ib.stall),
                32'(vecs[i].ist));
            chk($sformatf("v%0d_dstall", i), 32'(db.stall),
                32'(vecs[i].dst));
            chk($sformatf("v%0d_mrd", i), 32'(mb.read), 32'(vecs[i].mrd));
            chk($sformatf("v%0d_mwr", i), 32'(mb.write), 32'(vecs[i].mwr));
            chk($sformatf("v%0d_addr", i), mb.address,
                sel_addr(vecs[i].sel));
            chk($sformatf("v%0d_irdata", i), ib.data_rd,
                (vecs[i].sel == 2'd2) ? d : 32'h0);
            chk($sformatf("v%0d_drdata", i), db.data_rd,
                (vecs[i].sel == 2'd1) ? d : 32'h0);
            next_cycle();
        end

        // Starvation guard: inst forced in on the 9th losing cycle.
        reset_pulse();
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 1, 0, 0, 32'hAB00_0000 + 32'(c));
            @(negedge clk);
            chk($sformatf("st%0d_wait", c), 32'(dut.u_starve.wait_cnt),
                (c == 9) ? 32'h0 : 32'(c));
            chk($sformatf("st%0d_addr", c), mb.address,
                (c == 8) ? IADDR : DADDR);
            chk($sformatf("st%0d_istall", c), 32'(ib.stall),
                (c == 8) ? 32'h0 : 32'h1);
            chk($sformatf("st%0d_dstall", c), 32'(db.stall),
                (c == 8) ? 32'h1 : 32'h0);
            next_cycle();
        end

        // Reset while INST owns a stalled transfer.
        reset_pulse();
        drive(1, 0, 1, 0, 1, 32'h0);
        next_cycle();
        next_cycle();
        drive(1, 0, 1, 0, 0, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 1, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rs_owner_inst", 32'(owner), 32'h2);
        chk("rs_wait_held", 32'(dut.u_starve.wait_cnt), 32'h3);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rs_mem_read", 32'(mb.read), 32'h0);
        chk("rs_mem_write", 32'(mb.write), 32'h0);
        chk("rs_inst_stall", 32'(ib.stall), 32'h0);
        chk("rs_data_stall", 32'(db.stall), 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("rs_owner_clr", 32'(owner), 32'h0);
        chk("rs_wait_clr", 32'(dut.u_starve.wait_cnt), 32'h0);
        chk("rs_mem_read_after", 32'(mb.read), 32'h0);
        next_cycle();
`else
        // Round-robin: continuous dual requests alternate starting at INST.
        reset_pulse();
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, 1, 0, 0, 32'h5A00_0000 + 32'(c));
            @(negedge clk);
            chk($sformatf("rr%0d_addr", c), mb.address,
                (c % 2 == 0) ? IADDR : DADDR);
            chk($sformatf("rr%0d_istall", c), 32'(ib.stall),
                (c % 2 == 0) ? 32'h0 : 32'h1);
            next_cycle();
        end
`endif

        mb.interrupt = 6'b000001;
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("irq_data", 32'(db.interrupt), 32'h1);
        chk("irq_inst", 32'(ib.interrupt), 32'h0);
        next_cycle();

        reset_pulse();
        m_owner = 0; m_wait = 0; m_last = 1'b0;
        ipend = 1'b0; dpend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!ipend) begin
                k = $urandom_range(0, 2);
                ib.read = (k == 1); ib.write = (k == 2);
                ib.address = $urandom; ib.data_wr = $urandom;
                ib.mask = 4'($urandom);
            end
            if (!dpend) begin
                k = $urandom_range(0, 2);
                db.read = (k == 1); db.write = (k == 2);
                db.address = $urandom; db.data_wr = $urandom;
                db.mask = 4'($urandom);
            end
            mb.stall = ($urandom_range(0, 9) < 4);
            mb.data_rd = $urandom;
            mb.interrupt = 6'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            model_eval();
            check_model("rnd_");
            ipend = (ib.read | ib.write) && e_ist;
            dpend = (db.read | db.write) && e_dst;
            model_update();
            next_cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
